// File: rtl/arbitro_periferico.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : arbitro_periferico
// Brief    : Two-port round-robin arbiter sharing one four-phase peripheral
//            handshake channel, with per-phase timeout and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_periferico #(
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clkARB,
   input  logic        rstARB,
   input  logic [1:0]  inSend0,
   input  logic [1:0]  inSend1,
   input  logic [15:0] inData0,
   input  logic [15:0] inData1,
   output logic [1:0]  outAck0,
   output logic [1:0]  outAck1,
   output logic [1:0]  outSend,
   output logic [15:0] outData,
   input  logic [1:0]  inAck,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        errTimeout
);

   localparam logic [15:0] C_TIMER_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEND    = 3'd1,
      S_RELEASE = 3'd2,
      S_DONE    = 3'd3
   } stateT;

   stateT r_state, w_stateNext;

   logic [SYNC_STAGES-1:0][1:0] r_send0Sync, r_send1Sync, r_ackSync;

   logic        r_lastGrant, w_lastGrantNext;
   logic [1:0]  r_grant, w_grantNext;
   logic [1:0]  r_outSend, w_outSendNext;
   logic [15:0] r_outData, w_outDataNext;
   logic [1:0]  r_ack0, w_ack0Next;
   logic [1:0]  r_ack1, w_ack1Next;
   logic        r_errTimeout, w_errTimeoutNext;
   logic [15:0] r_timer, w_timerNext;

   logic w_req0, w_req1, w_ackHi, w_winReq, w_timeoutHit;

   // Codes move 00<->01 one bit at a time, so per-bit synchronisation is safe.
   always_ff @(posedge clkARB or negedge rstARB) begin
      if (!rstARB) begin
         r_send0Sync <= '0;
         r_send1Sync <= '0;
         r_ackSync   <= '0;
      end else begin
         r_send0Sync <= {r_send0Sync[SYNC_STAGES-2:0], inSend0};
         r_send1Sync <= {r_send1Sync[SYNC_STAGES-2:0], inSend1};
         r_ackSync   <= {r_ackSync[SYNC_STAGES-2:0], inAck};
      end
   end

   assign w_req0       = (r_send0Sync[SYNC_STAGES-1] == 2'b01);
   assign w_req1       = (r_send1Sync[SYNC_STAGES-1] == 2'b01);
   assign w_ackHi      = (r_ackSync[SYNC_STAGES-1] == 2'b01);
   assign w_winReq     = r_grant[1] ? w_req1 : w_req0;
   assign w_timeoutHit = (r_timer == C_TIMER_LAST);

   always_ff @(posedge clkARB or negedge rstARB) begin
      if (!rstARB) begin
         r_state      <= S_IDLE;
         r_lastGrant  <= 1'b1;
         r_grant      <= 2'b00;
         r_outSend    <= 2'b00;
         r_outData    <= 16'h0000;
         r_ack0       <= 2'b00;
         r_ack1       <= 2'b00;
         r_errTimeout <= 1'b0;
         r_timer      <= 16'h0000;
      end else begin
         r_state      <= w_stateNext;
         r_lastGrant  <= w_lastGrantNext;
         r_grant      <= w_grantNext;
         r_outSend    <= w_outSendNext;
         r_outData    <= w_outDataNext;
         r_ack0       <= w_ack0Next;
         r_ack1       <= w_ack1Next;
         r_errTimeout <= w_errTimeoutNext;
         r_timer      <= w_timerNext;
      end
   end

   always_comb begin
      w_stateNext      = r_state;
      w_lastGrantNext  = r_lastGrant;
      w_grantNext      = r_grant;
      w_outSendNext    = r_outSend;
      w_outDataNext    = r_outData;
      w_ack0Next       = r_ack0;
      w_ack1Next       = r_ack1;
      w_errTimeoutNext = r_errTimeout;
      w_timerNext      = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

      case (r_state)
         S_IDLE: begin
            w_timerNext = 16'h0000;
            // On a tie the requester that did not win last time goes first.
            if (w_req0 && (!w_req1 || r_lastGrant)) begin
               w_grantNext     = 2'b01;
               w_lastGrantNext = 1'b0;
               w_outDataNext   = inData0;
               w_outSendNext   = 2'b01;
               w_stateNext     = S_SEND;
            end else if (w_req1) begin
               w_grantNext     = 2'b10;
               w_lastGrantNext = 1'b1;
               w_outDataNext   = inData1;
               w_outSendNext   = 2'b01;
               w_stateNext     = S_SEND;
            end
         end
         S_SEND: begin
            if (w_ackHi) begin
               w_outSendNext = 2'b00;
               w_timerNext   = 16'h0000;
               w_stateNext   = S_RELEASE;
            end else if (w_timeoutHit) begin
               w_outSendNext    = 2'b00;
               w_errTimeoutNext = 1'b1;
               w_timerNext      = 16'h0000;
               w_stateNext      = S_DONE;
               if (r_grant[1]) w_ack1Next = 2'b10;
               else            w_ack0Next = 2'b10;
            end
         end
         S_RELEASE: begin
            if (!w_ackHi) begin
               w_timerNext = 16'h0000;
               w_stateNext = S_DONE;
               if (r_grant[1]) w_ack1Next = 2'b01;
               else            w_ack0Next = 2'b01;
            end else if (w_timeoutHit) begin
               w_outSendNext    = 2'b00;
               w_errTimeoutNext = 1'b1;
               w_timerNext      = 16'h0000;
               w_stateNext      = S_DONE;
               if (r_grant[1]) w_ack1Next = 2'b10;
               else            w_ack0Next = 2'b10;
            end
         end
         S_DONE: begin
            w_timerNext = 16'h0000;
            if (!w_winReq) begin
               w_ack0Next  = 2'b00;
               w_ack1Next  = 2'b00;
               w_grantNext = 2'b00;
               w_stateNext = S_IDLE;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   assign outAck0    = r_ack0;
   assign outAck1    = r_ack1;
   assign outSend    = r_outSend;
   assign outData    = r_outData;
   assign grant      = r_grant;
   assign busy       = (r_state != S_IDLE);
   assign errTimeout = r_errTimeout;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_periferico.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_arbitro_periferico
// Brief    : Directed self-checking bench for the two-port peripheral arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_periferico;

   logic clk = 1'b0, clkReq = 1'b0, clkPer = 1'b0;
   always #5   clk    = ~clk;
   always #4   clkReq = ~clkReq;
   always #8.5 clkPer = ~clkPer;

   logic        rstN = 1'b0;
   logic [1:0]  send0 = 2'b00, send1 = 2'b00;
   logic [15:0] data0 = 16'h0000, data1 = 16'h0000;
   logic [1:0]  ack0, ack1, pSend, grant;
   logic [15:0] pData;
   logic        busy, errTo;
   logic [1:0]  pAckMan = 2'b00, pAckAuto = 2'b00;
   logic        perAuto = 1'b0;
   logic [1:0]  pAck;
   assign pAck = perAuto ? pAckAuto : pAckMan;

   logic [1:0]  tSend0 = 2'b00, tInAck = 2'b00;
   logic [15:0] tData0 = 16'h0000;
   logic [1:0]  tAck0, tAck1, tOutSend, tGrant;
   logic [15:0] tOutData;
   logic        tBusy, tErr;

   arbitro_periferico u_dut (
      .clkARB(clk), .rstARB(rstN),
      .inSend0(send0), .inSend1(send1), .inData0(data0), .inData1(data1),
      .outAck0(ack0), .outAck1(ack1), .outSend(pSend), .outData(pData),
      .inAck(pAck), .grant(grant), .busy(busy), .errTimeout(errTo)
   );

   arbitro_periferico #(.TIMEOUT(8)) u_dutTo (
      .clkARB(clk), .rstARB(rstN),
      .inSend0(tSend0), .inSend1(2'b00), .inData0(tData0), .inData1(16'h0000),
      .outAck0(tAck0), .outAck1(tAck1), .outSend(tOutSend), .outData(tOutData),
      .inAck(tInAck), .grant(tGrant), .busy(tBusy), .errTimeout(tErr)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] exp0[$], exp1[$], perLog[$];

   // Free-running peripheral on its own clock for the asynchronous run.
   always @(posedge clkPer) begin
      if (!perAuto) begin
         pAckAuto <= 2'b00;
      end else if (pAckAuto == 2'b00 && pSend == 2'b01) begin
         perLog.push_back(pData);
         pAckAuto <= 2'b01;
      end else if (pAckAuto == 2'b01 && pSend == 2'b00) begin
         pAckAuto <= 2'b00;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      tick(2);
      @(negedge clk);
      rstN = 1'b1;
      tick(1);
   endtask

   // Manual peripheral: raise ack, let SEND see it, drop it, let RELEASE see it.
   task automatic periphHs();
      pAckMan = 2'b01;
      tick(3);
      pAckMan = 2'b00;
      tick(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   int          guard, g0, g1, i0, i1;
   logic [1:0]  expG;

   initial begin
      // Reset values
      tick(2);
      check("rstAck0", ack0, 2'b00);
      check("rstAck1", ack1, 2'b00);
      check("rstSend", pSend, 2'b00);
      check("rstData", pData, 16'h0000);
      check("rstGrant", grant, 2'b00);
      check("rstBusy", busy, 1'b0);
      check("rstErr", errTo, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
      tick(1);

      // Single request with reserved-ack rejection
      send0 = 2'b01; data0 = 16'hA5A5;
      tick(2);
      check("reqLatency", pSend, 2'b00);
      tick(1);
      check("singleSend", pSend, 2'b01);
      check("singleGrant", grant, 2'b01);
      check("singleData", pData, 16'hA5A5);
      check("singleBusy", busy, 1'b1);
      pAckMan = 2'b10;
      tick(4);
      check("reservedAck", pSend, 2'b01);
      pAckMan = 2'b00;
      tick(1);
      pAckMan = 2'b01;
      tick(2);
      check("ackLatency", pSend, 2'b01);
      tick(1);
      check("ackRelease", pSend, 2'b00);
      pAckMan = 2'b00;
      tick(2);
      check("doneLatency", ack0, 2'b00);
      tick(1);
      check("singleAck0", ack0, 2'b01);
      check("singleAck1", ack1, 2'b00);
      check("doneBusy", busy, 1'b1);
      send0 = 2'b00;
      tick(2);
      check("ackHold", ack0, 2'b01);
      tick(1);
      check("ackClear", ack0, 2'b00);
      check("idleGrant", grant, 2'b00);
      check("idleBusy", busy, 1'b0);
      check("dataHeld", pData, 16'hA5A5);

      // Simultaneous requests straight from reset
      doReset();
      send0 = 2'b01; data0 = 16'h1111;
      send1 = 2'b01; data1 = 16'h2222;
      tick(3);
      check("tieGrant0", grant, 2'b01);
      check("tieData0", pData, 16'h1111);
      periphHs();
      check("tieAck0", ack0, 2'b01);
      check("tieAck1Idle", ack1, 2'b00);
      send0 = 2'b00;
      tick(3);
      check("tieIdleGrant", grant, 2'b00);
      check("tieIdleBusy", busy, 1'b0);
      tick(1);
      check("tieGrant1", grant, 2'b10);
      check("tieData1", pData, 16'h2222);
      check("tieSend1", pSend, 2'b01);
      periphHs();
      check("tieAck1", ack1, 2'b01);
      send1 = 2'b00;
      tick(3);
      check("tieAck1Clear", ack1, 2'b00);

      // Fairness with both requesters continuously asking
      send0 = 2'b01; send1 = 2'b01;
      for (int i = 0; i < 6; i++) begin
         expG = (i % 2 == 0) ? 2'b01 : 2'b10;
         guard = 0;
         while (grant == 2'b00 && guard < 20) begin
            tick(1);
            guard++;
         end
         check($sformatf("fairGrant%0d", i), grant, expG);
         check($sformatf("fairData%0d", i), pData, (i % 2 == 0) ? 16'h1111 : 16'h2222);
         periphHs();
         if (expG == 2'b01) begin
            check($sformatf("fairAck%0d", i), ack0, 2'b01);
            send0 = 2'b00;
         end else begin
            check($sformatf("fairAck%0d", i), ack1, 2'b01);
            send1 = 2'b00;
         end
         if (i == 5) begin
            send0 = 2'b00;
            send1 = 2'b00;
         end
         tick(3);
         check($sformatf("fairIdle%0d", i), busy, 1'b0);
         if (i < 5) begin
            if (expG == 2'b01) send0 = 2'b01;
            else               send1 = 2'b01;
         end
      end
      tick(3);
      check("noSpurious", grant, 2'b00);

      // Reserved send code is idle
      send0 = 2'b11;
      tick(5);
      check("reservedSend", grant, 2'b00);
      check("reservedBusy", busy, 1'b0);
      send0 = 2'b00;
      tick(1);

      // Reset while in RELEASE
      send1 = 2'b01; data1 = 16'h3333;
      tick(3);
      check("midGrant", grant, 2'b10);
      pAckMan = 2'b01;
      tick(3);
      check("midRelSend", pSend, 2'b00);
      check("midRelBusy", busy, 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      check("midRstAck0", ack0, 2'b00);
      check("midRstAck1", ack1, 2'b00);
      check("midRstSend", pSend, 2'b00);
      check("midRstData", pData, 16'h0000);
      check("midRstGrant", grant, 2'b00);
      check("midRstBusy", busy, 1'b0);
      check("midRstErr", errTo, 1'b0);
      send1 = 2'b00; pAckMan = 2'b00;
      @(negedge clk);
      rstN = 1'b1;
      tick(1);
      send1 = 2'b01; data1 = 16'h4444;
      tick(3);
      check("postRstGrant", grant, 2'b10);
      check("postRstData", pData, 16'h4444);
      periphHs();
      check("postRstAck1", ack1, 2'b01);
      send1 = 2'b00;
      tick(3);
      check("postRstIdle", busy, 1'b0);

      // Timeout on the TIMEOUT=8 instance
      tSend0 = 2'b01; tData0 = 16'h5A5A;
      tick(3);
      check("toSend", tOutSend, 2'b01);
      check("toData", tOutData, 16'h5A5A);
      tick(7);
      check("toNotYet", tOutSend, 2'b01);
      check("toErrNotYet", tErr, 1'b0);
      tick(1);
      check("toAbortSend", tOutSend, 2'b00);
      check("toAck0", tAck0, 2'b10);
      check("toErr", tErr, 1'b1);
      check("toBusy", tBusy, 1'b1);
      check("toGrant", tGrant, 2'b01);
      tSend0 = 2'b00;
      tick(3);
      check("toAckClear", tAck0, 2'b00);
      check("toIdle", tBusy, 1'b0);
      check("toErrSticky", tErr, 1'b1);
      tSend0 = 2'b01; tData0 = 16'h6B6B;
      tick(3);
      tInAck = 2'b01;
      tick(3);
      check("to2Release", tOutSend, 2'b00);
      tInAck = 2'b00;
      tick(3);
      check("to2Ack0", tAck0, 2'b01);
      check("to2ErrSticky", tErr, 1'b1);
      tSend0 = 2'b00;
      tick(3);
      check("to2Idle", tAck0, 2'b00);

      // Requesters and peripheral on unrelated clocks
      perAuto = 1'b1;
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               @(negedge clkReq);
               data0 = {1'b0, 15'($urandom)};
               exp0.push_back(data0);
               send0 = 2'b01;
               g0 = 0;
               while (ack0 == 2'b00 && g0 < 5000) begin @(negedge clkReq); g0++; end
               check($sformatf("asyncAck0_%0d", k), ack0, 2'b01);
               send0 = 2'b00;
               g0 = 0;
               while (ack0 != 2'b00 && g0 < 5000) begin @(negedge clkReq); g0++; end
               check($sformatf("asyncRel0_%0d", k), ack0, 2'b00);
               repeat ($urandom_range(0, 3)) @(negedge clkReq);
            end
         end
         begin
            for (int k = 0; k < 25; k++) begin
               @(negedge clkReq);
               data1 = {1'b1, 15'($urandom)};
               exp1.push_back(data1);
               send1 = 2'b01;
               g1 = 0;
               while (ack1 == 2'b00 && g1 < 5000) begin @(negedge clkReq); g1++; end
               check($sformatf("asyncAck1_%0d", k), ack1, 2'b01);
               send1 = 2'b00;
               g1 = 0;
               while (ack1 != 2'b00 && g1 < 5000) begin @(negedge clkReq); g1++; end
               check($sformatf("asyncRel1_%0d", k), ack1, 2'b00);
               repeat ($urandom_range(0, 3)) @(negedge clkReq);
            end
         end
      join
      tick(20);
      check("asyncTotal", perLog.size(), 50);
      i0 = 0;
      i1 = 0;
      foreach (perLog[j]) begin
         if (perLog[j][15] == 1'b0) begin
            if (i0 < exp0.size()) check($sformatf("asyncData0_%0d", i0), perLog[j], exp0[i0]);
            i0++;
         end else begin
            if (i1 < exp1.size()) check($sformatf("asyncData1_%0d", i1), perLog[j], exp1[i1]);
            i1++;
         end
      end
      check("asyncCount0", i0, 25);
      check("asyncCount1", i1, 25);
      check("asyncErr", errTo, 1'b0);
      check("asyncIdle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arbitro_periferico.md
# arbitro_periferico

Two-port round-robin arbiter that shares one peripheral handshake channel between two requesters. It sits between requester-side send/data/ack channels and a single peripheral with the same channel format. It runs its own four-phase handshake toward the peripheral and returns a completion or timeout code to the winning requester. All channel inputs are asynchronous to the arbiter clock and are synchronised internally.

## Interface
- TIMEOUT, 255: clock cycles to wait for each peripheral ack edge before aborting; legal range 1..65535.
- SYNC_STAGES, 2: flip-flop stages on every asynchronous control input; minimum 2.
- clkARB  in  1  arbiter clock; the only clock.
- rstARB  in  1  asynchronous, active-low reset.
- inSend0 / inSend1  in  2 each  requester 0/1 send code: 2'b01 means request with data stable; any other value means idle.
- inData0 / inData1  in  16 each  requester 0/1 payload; stable while its send is 2'b01.
- outAck0 / outAck1  out  2 each  to requester 0/1: 2'b00 idle, 2'b01 done, 2'b10 timeout.
- outSend  out  2  to peripheral: 2'b01 request, 2'b00 idle.
- outData  out  16  to peripheral; latched payload of the granted requester.
- inAck  in  2  from peripheral: 2'b01 ack, anything else low.
- grant  out  2  one-hot owner of the channel; 2'b00 when idle.
- busy  out  1  high in any state other than IDLE.
- errTimeout  out  1  sticky; set on any abort; cleared only by reset.

## Operation
- Reset (async, rstARB=0) puts every output at 0: outAck0/1=00, outSend=00, outData=0, grant=00, busy=0, errTimeout=0. State goes to IDLE and lastGrant=1, so requester 0 wins the first tie.
- reqN = (synchronised inSendN == 2'b01). ackHi = (synchronised inAck == 2'b01).
- IDLE
  - No reqN: stay in IDLE.
  - Exactly one reqN: grant it.
  - Both reqN: grant the requester that is not lastGrant.
  - On grant: latch inDataN into outData, set grant and lastGrant, outSend=01, timer=0, go to SEND.
- SEND: wait for ackHi.
  - On ackHi: outSend=00, timer=0, go to RELEASE.
  - On timer==TIMEOUT-1: abort.
- RELEASE: wait for !ackHi.
  - On !ackHi: set winner outAck=01, go to DONE.
  - On timer==TIMEOUT-1: abort.
- Abort: outSend=00, winner outAck=10, errTimeout=1, go to DONE.
- DONE: hold winner outAck until the winner's req goes low, then outAck=00, grant=00, go to IDLE.
- The loser's request stays pending and is served next; it is never dropped.
- A request that appears while busy is ignored until IDLE.
- outData changes only on a grant.
- The timer is 16 bits, saturating, and cleared on every state entry.
- Reserved send/ack codes (10, 11) are treated as low.

## Timing
- Input to output latency:
  - Raw inSendN=01 stable before edge k gives reqN visible after edge k+SYNC_STAGES-1.
  - outSend=01 appears at edge k+SYNC_STAGES, i.e. 2 cycles at default.
- Peripheral ack to release: inAck rise to outSend=00 is SYNC_STAGES cycles.
- inAck fall to outAck=01 is SYNC_STAGES cycles.
- Requester send fall to outAck=00 is SYNC_STAGES cycles; the next grant is possible on the following edge.
- Minimum back-to-back turnaround is 1 IDLE cycle between transactions.
- Timeout fires exactly TIMEOUT cycles after entry to SEND or RELEASE.
- Reset asserted mid-transaction clears all outputs asynchronously with no partial ack. The peripheral and requesters must also be reset.

## Test plan
- Single request: req0 sends data 16'hA5A5 with a peripheral acking after 5 cycles. Required: outData=A5A5, grant=01, outSend 01 then 00, outAck0=01, and a return to IDLE with busy=0.
- Simultaneous requests from reset: req0 sends 1111 and req1 sends 2222 together. Required: req0 is served first, then req1 with grant=10 and outData=2222; both ack 01.
- Fairness: both requesters held permanently high for 6 transactions. Required: grants alternate 01,10,01,10,01,10.
- Timeout: TIMEOUT=8, peripheral never acks. Required: 8 cycles after SEND, outSend=00, outAck0=10 and errTimeout=1. The next transaction (peripheral now acking) returns 01 while errTimeout stays 1.
- Reset mid-transfer: rstARB driven low while in RELEASE. Required: all outputs are 0 immediately; after release, a new req1 is granted normally.
- Asynchronous clocks: peripheral clocked at 17 ns period, requesters at 8 ns, arbiter at 10 ns, for 50 random transfers. Required: no lost or duplicated transfer, and the data sequence is identical at the peripheral.
